// File: rtl/core_regfile_ctrl.sv
// Register-file front end: busy scoreboard for RAW/WAW hazards, ALU/LSU writeback
// arbitration with starvation guard, and same-edge write forwarding into operands.
module core_regfile_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        iss_valid_i,
    output logic        iss_ready_o,
    input  logic [4:0]  iss_rs0_addr_i,
    input  logic [4:0]  iss_rs1_addr_i,
    input  logic        iss_rd_we_i,
    input  logic [4:0]  iss_rd_addr_i,
    output logic        op_valid_o,
    output logic [31:0] op_rs0_data_o,
    output logic [31:0] op_rs1_data_o,
    output logic [4:0]  rf_rs0_addr_o,
    output logic [4:0]  rf_rs1_addr_o,
    input  logic [31:0] rf_rs0_data_i,
    input  logic [31:0] rf_rs1_data_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_rd_data_o,
    input  logic        wb0_valid_i,
    input  logic        wb1_valid_i,
    output logic        wb0_ready_o,
    output logic        wb1_ready_o,
    input  logic [4:0]  wb0_addr_i,
    input  logic [4:0]  wb1_addr_i,
    input  logic [31:0] wb0_data_i,
    input  logic [31:0] wb1_data_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [31:0] busy_reg, busy_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        op_valid_reg;
    logic [4:0]  fwd_rs0_reg, fwd_rs1_reg, fwd_addr_reg;
    logic        fwd_we_reg;
    logic [31:0] fwd_data_reg;

    logic        starved, wb0_grant, wb1_grant, grant, write_en;
    logic [4:0]  gnt_addr;
    logic [31:0] gnt_data;
    logic        rs0_blocked, rs1_blocked, rd_blocked, issue_fire, busy_set;

    always_comb begin
        starved   = (starve_cnt_reg == LIMIT);
        wb0_grant = wb0_valid_i && (!wb1_valid_i || starved);
        wb1_grant = wb1_valid_i && !wb0_grant;
        grant     = wb0_grant || wb1_grant;
        gnt_addr  = wb0_grant ? wb0_addr_i : wb1_addr_i;
        gnt_data  = wb0_grant ? wb0_data_i : wb1_data_i;
        write_en  = grant && (gnt_addr != 5'd0);

        // A register being written this cycle no longer blocks an issue.
        rs0_blocked = busy_reg[iss_rs0_addr_i] && !(grant && gnt_addr == iss_rs0_addr_i);
        rs1_blocked = busy_reg[iss_rs1_addr_i] && !(grant && gnt_addr == iss_rs1_addr_i);
        rd_blocked  = iss_rd_we_i && busy_reg[iss_rd_addr_i]
                      && !(grant && gnt_addr == iss_rd_addr_i);
        iss_ready_o = !(rs0_blocked || rs1_blocked || rd_blocked);
        issue_fire  = iss_valid_i && iss_ready_o;
        busy_set    = issue_fire && iss_rd_we_i;

        if (wb0_grant)
            starve_cnt_next = 4'd0;
        else if (wb0_valid_i && !starved)
            starve_cnt_next = starve_cnt_reg + 4'd1;
        else
            starve_cnt_next = starve_cnt_reg;
    end

    // Set takes precedence over clear so a WAW reissue keeps the register busy.
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            assign busy_next[gi] = (busy_set && iss_rd_addr_i == 5'(gi))
                                   || (busy_reg[gi] && !(grant && gnt_addr == 5'(gi)));
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_reg       <= '0;
            starve_cnt_reg <= '0;
            op_valid_reg   <= 1'b0;
            fwd_rs0_reg    <= '0;
            fwd_rs1_reg    <= '0;
            fwd_addr_reg   <= '0;
            fwd_we_reg     <= 1'b0;
            fwd_data_reg   <= '0;
        end else begin
            busy_reg       <= busy_next;
            starve_cnt_reg <= starve_cnt_next;
            op_valid_reg   <= issue_fire;
            if (issue_fire) begin
                fwd_rs0_reg  <= iss_rs0_addr_i;
                fwd_rs1_reg  <= iss_rs1_addr_i;
                fwd_we_reg   <= write_en;
                fwd_addr_reg <= gnt_addr;
                fwd_data_reg <= gnt_data;
            end
        end
    end

    assign wb0_ready_o   = wb0_grant;
    assign wb1_ready_o   = wb1_grant;
    assign rf_we_o       = write_en;
    assign rf_rd_addr_o  = gnt_addr;
    assign rf_rd_data_o  = gnt_data;
    assign rf_rs0_addr_o = iss_rs0_addr_i;
    assign rf_rs1_addr_o = iss_rs1_addr_i;
    assign op_valid_o    = op_valid_reg;

    // The register file reads old data on a same-edge write, so patch it here.
    assign op_rs0_data_o = !op_valid_reg ? 32'd0
                         : (fwd_we_reg && fwd_addr_reg == fwd_rs0_reg) ? fwd_data_reg
                         : rf_rs0_data_i;
    assign op_rs1_data_o = !op_valid_reg ? 32'd0
                         : (fwd_we_reg && fwd_addr_reg == fwd_rs1_reg) ? fwd_data_reg
                         : rf_rs1_data_i;

endmodule

// File: tb/tb_core_regfile_ctrl.sv
// Bench for core_regfile_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a behavioural scoreboard/regfile model.
module tb_core_regfile_ctrl;

    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        iss_valid_i, iss_ready_o, iss_rd_we_i;
    logic [4:0]  iss_rs0_addr_i, iss_rs1_addr_i, iss_rd_addr_i;
    logic        op_valid_o;
    logic [31:0] op_rs0_data_o, op_rs1_data_o;
    logic [4:0]  rf_rs0_addr_o, rf_rs1_addr_o, rf_rd_addr_o;
    logic [31:0] rf_rs0_data_i, rf_rs1_data_i, rf_rd_data_o;
    logic        rf_we_o;
    logic        wb0_valid_i, wb1_valid_i, wb0_ready_o, wb1_ready_o;
    logic [4:0]  wb0_addr_i, wb1_addr_i;
    logic [31:0] wb0_data_i, wb1_data_i;

    int checks = 0;
    int errors = 0;

    core_regfile_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
        .iss_rs0_addr_i(iss_rs0_addr_i), .iss_rs1_addr_i(iss_rs1_addr_i),
        .iss_rd_we_i(iss_rd_we_i), .iss_rd_addr_i(iss_rd_addr_i),
        .op_valid_o(op_valid_o), .op_rs0_data_o(op_rs0_data_o), .op_rs1_data_o(op_rs1_data_o),
        .rf_rs0_addr_o(rf_rs0_addr_o), .rf_rs1_addr_o(rf_rs1_addr_o),
        .rf_rs0_data_i(rf_rs0_data_i), .rf_rs1_data_i(rf_rs1_data_i),
        .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
        .wb0_valid_i(wb0_valid_i), .wb1_valid_i(wb1_valid_i),
        .wb0_ready_o(wb0_ready_o), .wb1_ready_o(wb1_ready_o),
        .wb0_addr_i(wb0_addr_i), .wb1_addr_i(wb1_addr_i),
        .wb0_data_i(wb0_data_i), .wb1_data_i(wb1_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Register file: one-cycle registered read, old data on a same-edge write, never reset.
    logic [31:0] mem [32];
    always @(posedge clk_i) begin
        rf_rs0_data_i <= mem[rf_rs0_addr_o];
        rf_rs1_data_i <= mem[rf_rs1_addr_o];
        if (rf_we_o) mem[rf_rd_addr_o] <= rf_rd_data_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register values, a busy set, a starvation count.
    bit [31:0]   m_busy;
    int          m_starve;
    logic [31:0] m_regs [32];
    bit          m_pend;
    logic [31:0] m_op0, m_op1;
    logic [4:0]  m_a0, m_a1;

    function automatic bit blocked(input logic [4:0] r, input bit gv, input logic [4:0] ga,
                                   input bit [31:0] busy);
        return busy[r] && !(gv && ga == r);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]    = 32'd0;
            m_regs[i] = 32'd0;
        end
        m_busy = '0; m_starve = 0; m_pend = 1'b0;
    end

    always @(negedge clk_i) begin : model
        bit g0, g1, gv, ewe, rdy, hs;
        logic [4:0]  ga;
        logic [31:0] gd, v0, v1;
        if (!arst_ni) begin
            m_busy = '0; m_starve = 0; m_pend = 1'b0;
            chk("rst_op_valid", 32'(op_valid_o), 32'd0);
            chk("rst_op_rs0", op_rs0_data_o, 32'd0);
            chk("rst_op_rs1", op_rs1_data_o, 32'd0);
        end else begin
            chk("op_valid", 32'(op_valid_o), 32'(m_pend));
            if (m_pend) begin
                chk("op_rs0_data", op_rs0_data_o, m_op0);
                chk("op_rs1_data", op_rs1_data_o, m_op1);
                $display("operands x%0d=%h x%0d=%h", m_a0, op_rs0_data_o, m_a1, op_rs1_data_o);
            end
            // wb1 wins unless wb0 has already waited LIMIT cycles
            g0  = wb0_valid_i && (!wb1_valid_i || m_starve == LIMIT);
            g1  = wb1_valid_i && !g0;
            gv  = g0 || g1;
            ga  = g0 ? wb0_addr_i : wb1_addr_i;
            gd  = g0 ? wb0_data_i : wb1_data_i;
            ewe = gv && ga != 5'd0;
            chk("wb0_ready", 32'(wb0_ready_o), 32'(g0));
            chk("wb1_ready", 32'(wb1_ready_o), 32'(g1));
            chk("rf_we", 32'(rf_we_o), 32'(ewe));
            if (ewe) begin
                chk("rf_rd_addr", 32'(rf_rd_addr_o), 32'(ga));
                chk("rf_rd_data", rf_rd_data_o, gd);
            end
            chk("rf_rs0_addr", 32'(rf_rs0_addr_o), 32'(iss_rs0_addr_i));
            chk("rf_rs1_addr", 32'(rf_rs1_addr_o), 32'(iss_rs1_addr_i));
            rdy = !(blocked(iss_rs0_addr_i, gv, ga, m_busy) || blocked(iss_rs1_addr_i, gv, ga, m_busy)
                    || (iss_rd_we_i && blocked(iss_rd_addr_i, gv, ga, m_busy)));
            chk("iss_ready", 32'(iss_ready_o), 32'(rdy));
            hs = iss_valid_i && rdy;
            // operand value = register contents including the write landing on this edge
            v0 = (ewe && ga == iss_rs0_addr_i) ? gd : m_regs[iss_rs0_addr_i];
            v1 = (ewe && ga == iss_rs1_addr_i) ? gd : m_regs[iss_rs1_addr_i];
            m_pend = hs; m_op0 = v0; m_op1 = v1; m_a0 = iss_rs0_addr_i; m_a1 = iss_rs1_addr_i;
            if (ewe) m_regs[ga] = gd;
            if (gv) m_busy[ga] = 1'b0;
            if (hs && iss_rd_we_i && iss_rd_addr_i != 5'd0) m_busy[iss_rd_addr_i] = 1'b1;
            if (g0) m_starve = 0;
            else if (wb0_valid_i && m_starve < LIMIT) m_starve++;
        end
    end

    task automatic idle();
        iss_valid_i = 0; iss_rd_we_i = 0;
        iss_rs0_addr_i = 0; iss_rs1_addr_i = 0; iss_rd_addr_i = 0;
        wb0_valid_i = 0; wb1_valid_i = 0;
        wb0_addr_i = 0; wb1_addr_i = 0; wb0_data_i = 0; wb1_data_i = 0;
    endtask

    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic we, input logic [4:0] rd);
        iss_valid_i = 1; iss_rs0_addr_i = rs0; iss_rs1_addr_i = rs1;
        iss_rd_we_i = we; iss_rd_addr_i = rd;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        arst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_op_valid", 32'(op_valid_o), 32'd0);
        arst_ni = 1'b1;
        #1;
        chk("reset_iss_ready", 32'(iss_ready_o), 32'd1);
        chk("reset_wb0_ready", 32'(wb0_ready_o), 32'd0);

        // basic read
        wb1_valid_i = 1; wb1_addr_i = 5; wb1_data_i = 32'hDEADBEEF;
        #1;
        chk("basic_wb1_ready", 32'(wb1_ready_o), 32'd1);
        chk("basic_rf_we", 32'(rf_we_o), 32'd1);
        cyc(); idle(); cyc();
        issue(5, 0, 0, 0);
        #1;
        chk("basic_ready", 32'(iss_ready_o), 32'd1);
        cyc(); idle();
        chk("basic_op_valid", 32'(op_valid_o), 32'd1);
        chk("basic_op_rs0", op_rs0_data_o, 32'hDEADBEEF);
        cyc();
        chk("basic_op_pulse", 32'(op_valid_o), 32'd0);

        // RAW stall resolved by forwarding
        issue(0, 0, 1, 7);
        #1;
        chk("raw_first_ready", 32'(iss_ready_o), 32'd1);
        cyc(); issue(0, 7, 0, 0);
        #1;
        chk("raw_stall", 32'(iss_ready_o), 32'd0);
        cyc();
        #1;
        chk("raw_stall2", 32'(iss_ready_o), 32'd0);
        cyc(); wb0_valid_i = 1; wb0_addr_i = 7; wb0_data_i = 32'h1234;
        #1;
        chk("raw_release", 32'(iss_ready_o), 32'd1);
        chk("raw_wb0_ready", 32'(wb0_ready_o), 32'd1);
        cyc(); idle();
        chk("raw_op_valid", 32'(op_valid_o), 32'd1);
        chk("raw_op_rs1", op_rs1_data_o, 32'h1234);

        // arbitration with starvation guard
        wb0_valid_i = 1; wb0_addr_i = 10; wb0_data_i = 32'hA0A0;
        wb1_valid_i = 1; wb1_addr_i = 11; wb1_data_i = 32'hB1B1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("arb_wb0", 32'(wb0_ready_o), 32'(i % 5 == 4));
            chk("arb_wb1", 32'(wb1_ready_o), 32'(i % 5 != 4));
            cyc();
        end
        idle();

        // x0 handling
        wb0_valid_i = 1; wb0_addr_i = 0; wb0_data_i = 32'hFFFFFFFF;
        issue(0, 0, 1, 0);
        #1;
        chk("x0_wb0_ready", 32'(wb0_ready_o), 32'd1);
        chk("x0_rf_we", 32'(rf_we_o), 32'd0);
        chk("x0_ready", 32'(iss_ready_o), 32'd1);
        cyc(); wb0_valid_i = 0;
        #1;
        chk("x0_no_busy", 32'(iss_ready_o), 32'd1);
        chk("x0_op_rs0", op_rs0_data_o, 32'd0);
        cyc(); idle();

        // WAW with set-wins
        issue(0, 0, 1, 3);
        #1;
        chk("waw_first_ready", 32'(iss_ready_o), 32'd1);
        cyc();
        #1;
        chk("waw_stall", 32'(iss_ready_o), 32'd0);
        cyc(); wb1_valid_i = 1; wb1_addr_i = 3; wb1_data_i = 32'h33;
        #1;
        chk("waw_release", 32'(iss_ready_o), 32'd1);
        cyc(); idle(); issue(3, 0, 0, 0);
        #1;
        chk("waw_still_busy", 32'(iss_ready_o), 32'd0);
        wb1_valid_i = 1; wb1_addr_i = 3; wb1_data_i = 32'h44;
        #1;
        chk("waw_read_release", 32'(iss_ready_o), 32'd1);
        cyc(); idle();
        chk("waw_fwd_rs0", op_rs0_data_o, 32'h44);

        // reset between issue and operand cycle
        issue(5, 0, 1, 9);
        #1;
        chk("rst_mid_ready", 32'(iss_ready_o), 32'd1);
        cyc(); idle();
        #1;
        arst_ni = 1'b0;
        #1;
        chk("rst_mid_op_valid", 32'(op_valid_o), 32'd0);
        cyc();
        arst_ni = 1'b1;
        #1;
        chk("rst_mid_no_pulse", 32'(op_valid_o), 32'd0);
        issue(9, 9, 1, 9);
        #1;
        chk("rst_mid_busy_clear", 32'(iss_ready_o), 32'd1);
        cyc(); idle();
        chk("rst_mid_op_valid_after", 32'(op_valid_o), 32'd1);

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            iss_valid_i    = 1'($urandom_range(0, 1));
            iss_rs0_addr_i = 5'($urandom_range(0, 7));
            iss_rs1_addr_i = 5'($urandom_range(0, 7));
            iss_rd_we_i    = 1'($urandom_range(0, 1));
            iss_rd_addr_i  = 5'($urandom_range(0, 7));
            wb0_valid_i    = ($urandom_range(0, 99) < 60);
            wb1_valid_i    = ($urandom_range(0, 99) < 45);
            wb0_addr_i     = 5'($urandom_range(0, 7));
            wb1_addr_i     = 5'($urandom_range(0, 7));
            wb0_data_i     = $urandom;
            wb1_data_i     = $urandom;
            cyc();
        end
        idle();
        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_regfile_ctrl.md
# core_regfile_ctrl

Controller in front of `core_regfile`. It sequences operand reads around the register file's one-cycle registered read and keeps a 32-entry busy scoreboard for RAW and WAW hazards. It forwards a write that lands on the same edge as a read, and arbitrates the single write port between the ALU writeback (wb0) and the LSU writeback (wb1). It sits between the issue stage and the register file.

## Interface
- STARVE_LIMIT, 4: consecutive cycles wb0 may wait while wb1 wins before wb0 is force-granted; range 1..15.
- clk_i  in  1  clock, all state on rising edge
- arst_ni  in  1  reset, asynchronous, active-low
- iss_valid_i  in  1  issue request
- iss_ready_o  out  1  issue accepted this cycle (combinational)
- iss_rs0_addr_i, iss_rs1_addr_i  in  5  source register addresses
- iss_rd_we_i  in  1  instruction will write rd
- iss_rd_addr_i  in  5  destination register address
- op_valid_o  out  1  operands valid; one-cycle pulse
- op_rs0_data_o, op_rs1_data_o  out  32  operand data
- rf_rs0_addr_o, rf_rs1_addr_o  out  5  to register file read ports; equal to the iss_* addresses
- rf_rs0_data_i, rf_rs1_data_i  in  32  register file read data, one cycle after address
- rf_we_o  out  1  register file write enable
- rf_rd_addr_o  out  5  register file write address
- rf_rd_data_o  out  32  register file write data
- wb0_valid_i, wb1_valid_i  in  1  writeback request (ALU, LSU)
- wb0_ready_o, wb1_ready_o  out  1  writeback grant (combinational)
- wb0_addr_i, wb1_addr_i  in  5  writeback address
- wb0_data_i, wb1_data_i  in  32  writeback data

## Operation
- **Scoreboard:** `busy[31:0]`; `busy[0]` is always 0.
  - Set `busy[rd]` on an issue handshake with `iss_rd_we_i=1` and rd≠0.
  - Clear `busy[addr]` on a writeback grant.
  - Set and clear of the same bit in the same cycle: set wins.
- **Arbitration:** wb1 has fixed priority.
  - `starve_cnt` counts cycles where wb0 is valid and not granted; it saturates at STARVE_LIMIT and clears when wb0 is granted.
  - wb0 is granted when wb1 is not valid, or when `starve_cnt == STARVE_LIMIT`.
  - Exactly one grant per cycle at most.
- **Write port:**
  - `rf_we_o = grant && addr≠0`; `rf_rd_addr_o`/`rf_rd_data_o` are muxed from the granted source.
  - A write to x0 is granted (ready=1) but not performed.
- **Issue stall:** `iss_ready_o = 0` if any of the following is true, otherwise 1.
  - `busy[rs0]` and rs0 is not being written by this cycle's grant.
  - Same condition for rs1.
  - `iss_rd_we_i` and `busy[rd]` and rd is not being written by this cycle's grant.
- **Forwarding:**
  - On an issue handshake, register both read addresses plus this cycle's write (we, addr, data).
  - Next cycle, `op_rsN_data_o` = captured write data if captured we=1 and captured addr == captured rsN addr. Otherwise it is `rf_rsN_data_i`.
  - Reads of x0 return `rf_rs*_data_i`; the register file never writes x0, so this is 0 once x0 is initialised. Register contents are not reset.

## Timing
- **Reset values:** `op_valid_o=0`, `op_rs*_data_o=0`, `busy=0`, `starve_cnt=0`, forwarding registers 0. Combinational outputs follow their inputs immediately after reset release.
- **Reset mid-operation:** all busy bits and pending forwarding are dropped; no operand pulse follows.
- **Issue to operands:** handshake in cycle N gives `op_valid_o=1` with data in cycle N+1. Back-to-back issue gives one operand pulse per cycle.
- **Write visibility:**
  - Grant in cycle N with a read of the same register issued in N: forwarded at N+1.
  - Issue in N+1 or later: read from the register file.
- **Busy timing:** a bit set by an issue in N is visible to the stall logic in N+1. A grant in N frees an issue stalled on that register in the same cycle N.
- **Combinational paths:** ready and grant outputs are combinational from valids, addresses and registered state. There is no combinational path from `rf_rs*_data_i` to any ready.

## Test plan
- **Basic read:** reset, wb1 writes x5=0xDEADBEEF, issue rs0=x5 two cycles later -> `op_valid_o` one cycle after handshake, `op_rs0_data_o=0xDEADBEEF`.
- **RAW stall:** issue rd=x7 (we=1); next cycle issue rs1=x7 -> `iss_ready_o=0` until wb0 writes x7=0x1234. The stalled issue is accepted in the grant cycle and receives 0x1234 via forwarding.
- **Arbitration and starvation:** wb0 and wb1 both valid continuously, STARVE_LIMIT=4 -> wb1 granted 4 cycles, wb0 granted on the 5th, then pattern repeats; never two grants in one cycle.
- **x0 handling:** wb0 writes x0=0xFFFFFFFF -> `wb0_ready_o=1`, `rf_we_o=0`; issue rd=x0 never sets busy; rs0=x0 never stalls.
- **WAW and set-wins:** issue rd=x3; second issue rd=x3 stalls; it is accepted in the cycle x3 is granted and `busy[3]` remains 1 afterwards.
- **Reset mid-operation:** assert `arst_ni` low between an issue and its operand cycle -> `op_valid_o` low immediately, busy cleared, first post-reset issue of any register is accepted without stall.
